// File: rtl/demux_stream4.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry registered buffer per channel.
// Optional packet lock (routing held for a whole packet) is enabled by defining DEMUX_PKT_LOCK_EN.
module demux_stream4 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // a sender holds data/select/last stable while valid is high and ready is low.

  logic [WIDTH-1:0] data_q [4];
  logic [1:0]       route;
  logic             accept;

`ifdef DEMUX_PKT_LOCK_EN
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  lock_state_t lock_state, lock_state_next;
  logic [1:0]  lock_sel, lock_sel_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= IDLE;
      lock_sel   <= 2'd0;
    end else begin
      lock_state <= lock_state_next;
      lock_sel   <= lock_sel_next;
    end
  end

  always_comb begin
    lock_state_next = lock_state;
    lock_sel_next   = lock_sel;
    route           = select;
    case (lock_state)
      IDLE: begin
        if (accept && !in_last) begin
          lock_state_next = LOCKED;
          lock_sel_next   = select;
        end
      end
      LOCKED: begin
        route = lock_sel;
        if (accept && in_last) lock_state_next = IDLE;
      end
      default: lock_state_next = IDLE;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = in_last;
  assign route       = select;
`endif

  // in_ready depends on select/out_ready combinationally, never on in_data.
  assign in_ready = ~rst & (~out_valid[route] | out_ready[route]);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 4'b0000;
      for (int n = 0; n < 4; n++) data_q[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (accept && (route == 2'(n))) begin
          out_valid[n] <= 1'b1;
          data_q[n]    <= in_data;
        end else if (out_ready[n]) begin
          out_valid[n] <= 1'b0;
        end
      end
    end
  end

  assign out0_data = data_q[0];
  assign out1_data = data_q[1];
  assign out2_data = data_q[2];
  assign out3_data = data_q[3];

endmodule

// File: tb/tb_demux_stream4.sv
// Bench for demux_stream4: directed steps plus randomized traffic against a per-channel queue model.
module tb_demux_stream4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [1:0] select;
  logic [1:0] out0_data, out1_data, out2_data, out3_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: beats waiting in each channel, last beat delivered to each channel, lock state.
  logic [1:0] exp_q [4][$];
  logic [1:0] last_data [4];
  bit         locked;
  logic [1:0] lock_sel;

  always #5 clk = ~clk;

  demux_stream4 #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .select    (select),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out3_data (out3_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] chan_data(input int n);
    case (n)
      0: return out0_data;
      1: return out1_data;
      2: return out2_data;
      default: return out3_data;
    endcase
  endfunction

  // One cycle: drive inputs, check in_ready, clock, update model, check all channels.
  task automatic step(input logic r, input logic v, input logic [1:0] d, input logic l,
                      input logic [1:0] s, input logic [3:0] rdy);
    logic [1:0] r_idx;
    logic       exp_ready;
    bit         acc;
    rst = r; in_valid = v; in_data = d; in_last = l; select = s; out_ready = rdy;
    r_idx = s;
`ifdef DEMUX_PKT_LOCK_EN
    if (locked) r_idx = lock_sel;
`endif
    exp_ready = !r && (exp_q[r_idx].size() == 0 || rdy[r_idx]);
    #1;
    check("in_ready", in_ready, exp_ready);
    acc = v && exp_ready;
    @(posedge clk);
    if (r) begin
      for (int n = 0; n < 4; n++) begin
        exp_q[n].delete();
        last_data[n] = 2'b00;
      end
      locked = 0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (rdy[n] && exp_q[n].size() != 0) void'(exp_q[n].pop_front());
      if (acc) begin
        exp_q[r_idx].push_back(d);
        last_data[r_idx] = d;
`ifdef DEMUX_PKT_LOCK_EN
        if (!locked && !l) begin
          locked   = 1;
          lock_sel = s;
        end else if (locked && l) begin
          locked = 0;
        end
`endif
      end
    end
    #1;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("out_valid[%0d]", n), out_valid[n], exp_q[n].size() != 0);
      check($sformatf("out%0d_data", n), chan_data(n), last_data[n]);
    end
  endtask

  initial begin
    logic       p_v, p_l;
    logic [1:0] p_d, p_s;
    logic       stalled;
    locked = 0;
    lock_sel = 2'b00;
    for (int n = 0; n < 4; n++) last_data[n] = 2'b00;
    rst = 1; in_valid = 0; in_data = 0; in_last = 0; select = 0; out_ready = 4'b0000;
    @(posedge clk); #1;

    // Reset held with a valid beat present.
    step(1, 1, 2'b10, 1, 2'd1, 4'b1111);
    step(1, 1, 2'b10, 1, 2'd1, 4'b1111);
    step(0, 1, 2'b10, 1, 2'd1, 4'b1111);

    // Routing across all four channels.
    step(0, 1, 2'b01, 1, 2'd0, 4'b1111);
    step(0, 1, 2'b10, 1, 2'd1, 4'b1111);
    step(0, 1, 2'b11, 1, 2'd2, 4'b1111);
    step(0, 1, 2'b00, 1, 2'd3, 4'b1111);
    step(0, 0, 2'b00, 1, 2'd0, 4'b1111);

    // Backpressure on ch2 while ch0 still accepts.
    step(0, 1, 2'b11, 1, 2'd2, 4'b1011);
    step(0, 1, 2'b01, 1, 2'd2, 4'b1011);
    step(0, 1, 2'b01, 1, 2'd2, 4'b1011);
    step(0, 1, 2'b10, 1, 2'd0, 4'b1011);
    step(0, 1, 2'b01, 1, 2'd2, 4'b1111);
    step(0, 0, 2'b00, 1, 2'd0, 4'b1111);

    // Drain plus refill on ch1, back to back.
    for (int i = 0; i < 4; i++) step(0, 1, 2'(i), 1, 2'd1, 4'b1111);
    step(0, 0, 2'b00, 1, 2'd0, 4'b1111);

    // Reset while ch3 is full and stalled.
    step(0, 1, 2'b10, 1, 2'd3, 4'b0111);
    step(0, 1, 2'b01, 1, 2'd3, 4'b0111);
    step(1, 0, 2'b00, 1, 2'd3, 4'b0111);
    step(0, 0, 2'b00, 1, 2'd3, 4'b1111);

`ifdef DEMUX_PKT_LOCK_EN
    // Three-beat packet locked to ch2, then an unlocked beat to ch0.
    step(0, 1, 2'b01, 0, 2'd2, 4'b1111);
    step(0, 1, 2'b10, 0, 2'd0, 4'b1111);
    step(0, 1, 2'b11, 1, 2'd0, 4'b1111);
    step(0, 1, 2'b00, 1, 2'd0, 4'b1111);
    // Reset mid-packet releases the lock.
    step(0, 1, 2'b01, 0, 2'd3, 4'b1111);
    step(1, 0, 2'b00, 0, 2'd0, 4'b1111);
    step(0, 1, 2'b11, 1, 2'd1, 4'b1111);
`endif

    // Randomized traffic; the producer holds its beat while stalled.
    stalled = 0;
    p_v = 0; p_d = 0; p_l = 1; p_s = 0;
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [3:0] rdy;
      r   = ($urandom_range(0, 39) == 0);
      rdy = 4'($urandom);
      if (!stalled) begin
        p_v = ($urandom_range(0, 3) != 0);
        p_d = 2'($urandom);
        p_s = 2'($urandom);
        p_l = ($urandom_range(0, 2) == 0);
      end
      step(r, p_v, p_d, p_l, p_s, rdy);
      stalled = p_v && !r && (in_valid && !dut.accept);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_stream4.md
Name: demux_stream4

Overview:
- 1-to-4 stream demultiplexer: the distribution-side counterpart of the team's 4:1 select mux.
- Routes one valid/ready input stream to one of four output channels, chosen by a 2-bit select.
- Each output channel has a one-entry registered buffer, so every output is registered and flow control is independent per channel.
- Sits between a single producer and four consumers, e.g. fanning out 2-bit symbols to four lanes.

Parameters:
- WIDTH, 2, data width of the input and of each output channel.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  WIDTH  input beat data.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the beat this cycle.
- in_last  input  1  last beat of a packet; used only with DEMUX_PKT_LOCK_EN, ignored otherwise.
- select  input  2  destination channel, 0..3.
- out0_data, out1_data, out2_data, out3_data  output  WIDTH each  channel data, registered.
- out_valid  output  4  bit n: channel n holds a beat.
- out_ready  input  4  bit n: consumer n takes the beat this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=4'b0000 and all outN_data=0.
  - Lock state returns to IDLE.
  - Any beat held in a buffer is discarded.
  - in_ready=0 while rst=1.
  - Reset takes priority over any simultaneous transfer.
- Routing index r:
  - select when unlocked.
  - the locked index when locked (see Optional Feature).
- in_ready = ~rst & (~out_valid[r] | out_ready[r]).
  - Combinational path from out_ready and select to in_ready.
  - No combinational path from in_data to any output.
- Input transfer: in_valid & in_ready at a rising edge.
  - On a transfer, the next cycle has outr_data=in_data and out_valid[r]=1.
  - Latency is 1 cycle; throughput is 1 beat/cycle per channel.
- Output transfer: out_valid[n] & out_ready[n].
  - Channel n clears out_valid[n] next cycle, unless an input transfer to n occurs in the same cycle; then it reloads with the new beat.
  - Same-cycle drain plus refill gives back-to-back beats with no bubble.
- Channel full and not drained (out_valid[r]=1, out_ready[r]=0): in_ready=0 and the input stalls.
  - Other channels keep draining independently.
  - The producer holds in_data, select and in_last stable while stalled.
- Data stability: outN_data holds while out_valid[N]=1 and out_ready[N]=0. It is not modified when no transfer targets N.
- in_valid=0: no state change except output drains.
- Ordering: beats to the same channel keep input order. No ordering is guaranteed across channels.
- No beat is lost or duplicated.

Optional Feature:
- Macro: DEMUX_PKT_LOCK_EN.
- Defined: packet lock, using a 2-state FSM (IDLE, LOCKED).
  - IDLE: r=select. An accepted beat with in_last=0 stores lock_sel=select and moves to LOCKED.
  - IDLE: an accepted beat with in_last=1 is a single-beat packet and stays in IDLE.
  - LOCKED: r=lock_sel, and select is ignored. An accepted beat with in_last=1 returns to IDLE.
  - rst forces IDLE mid-packet.
- Not defined:
  - No FSM; r=select on every beat.
  - in_last is unused.
  - Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0000, all data 0. After release, the first beat is accepted.
- Routing: beats 2'b01, 2'b10, 2'b11, 2'b00 with select 0, 1, 2, 3 and out_ready=1111 -> each appears one cycle later on out0..out3 respectively, out_valid one-hot per cycle.
- Backpressure:
  - out_ready[2]=0; send 2'b11 to ch2, then 2'b01 to ch2 -> second beat stalls (in_ready=0) and out2_data stays 2'b11.
  - Meanwhile a beat to ch0 is still accepted once select=0.
- Drain+refill: out_ready[1]=1 with 4 consecutive beats to ch1 (values 0,1,2,3) -> in_ready stays 1 and ch1 outputs 0,1,2,3 on consecutive cycles.
- Reset mid-stall: ch3 full and stalled, assert rst -> out_valid[3]=0 next cycle and the held beat is gone.
- With DEMUX_PKT_LOCK_EN:
  - 3-beat packet, first beat select=2, later beats select=0, in_last on beat 3 -> all 3 beats reach ch2.
  - The next beat, with select=0, reaches ch0.
  - rst after beat 1 of a packet -> the next beat routes by select.
